// File: rtl/iter_alu_if.sv
// iter_alu_if: request/answer bundle between the chip pad ring and iter_alu_core
interface iter_alu_if #(parameter int WIDTH = 64);
  logic             enable;
  logic [WIDTH-1:0] operand_1;
  logic [WIDTH-1:0] operand_2;
  logic [2:0]       mode;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;
  logic             error;
  modport master (output enable, operand_1, operand_2, mode, input result, done, busy, error);
  modport slave  (input enable, operand_1, operand_2, mode, output result, done, busy, error);
endinterface

// File: rtl/iter_alu_core.sv
// iter_alu_core: multi-cycle unsigned ALU with shift-add multiply and restoring divide
module iter_alu_core #(
  parameter int WIDTH    = 64,
  parameter int MUL_BITS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  iter_alu_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, ALU, MUL, DIV} state_t;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / MUL_BITS - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);
  state_t                 state_q, state_d;
  logic [2:0]             mode_q, mode_d;
  logic [WIDTH-1:0]       m_q, m_d, result_q, result_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   dz_q, dz_d, done_q, done_d, error_q, error_d;
  logic [WIDTH+MUL_BITS-1:0] part, msum;
  logic [2*WIDTH-1:0]     mul_nx, div_nx;
  logic [WIDTH:0]         shifted, diff;
  logic [WIDTH-1:0]       alu_val;
  logic                   b_zero, is_mul, is_div;
  // acc holds {partial product, remaining multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    part = '0;
    for (int i = 0; i < MUL_BITS; i++)
      if (acc_q[i]) part = part + ((WIDTH+MUL_BITS)'(m_q) << i);
    msum    = {{MUL_BITS{1'b0}}, acc_q[2*WIDTH-1:WIDTH]} + part;
    mul_nx  = {msum, acc_q[WIDTH-1:MUL_BITS]};
    shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff    = shifted - {1'b0, m_q};
    div_nx  = {diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0], acc_q[WIDTH-2:0], ~diff[WIDTH]};
  end
  always_comb begin
    b_zero  = bus.operand_2 == '0;
    is_mul  = bus.mode[2:1] == 2'b01;
    is_div  = bus.mode[2:1] == 2'b10 && !b_zero;
    alu_val = bus.mode == 3'd0 ? bus.operand_1 + bus.operand_2 :
              bus.mode == 3'd1 ? bus.operand_1 - bus.operand_2 :
              bus.mode == 3'd6 ? bus.operand_1 & bus.operand_2 :
              bus.mode == 3'd7 ? bus.operand_1 ^ bus.operand_2 :
              bus.mode == 3'd4 ? {WIDTH{1'b1}} : bus.operand_1;
  end
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    m_d      = m_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    dz_d     = dz_q;
    result_d = result_q;
    error_d  = error_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (bus.enable) begin
        mode_d  = bus.mode;
        error_d = 1'b0;
        dz_d    = bus.mode[2:1] == 2'b10 && b_zero;
        cnt_d   = is_mul ? MUL_LAST : DIV_LAST;
        m_d     = is_mul ? bus.operand_1 : bus.operand_2;
        acc_d   = {{WIDTH{1'b0}}, is_mul ? bus.operand_2 : is_div ? bus.operand_1 : alu_val};
        state_d = is_mul ? MUL : is_div ? DIV : ALU;
      end
      ALU: begin
        result_d = acc_q[WIDTH-1:0];
        error_d  = dz_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      MUL: begin
        acc_d = mul_nx;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          result_d = mode_q[0] ? mul_nx[2*WIDTH-1:WIDTH] : mul_nx[WIDTH-1:0];
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        acc_d = div_nx;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          result_d = mode_q[0] ? div_nx[2*WIDTH-1:WIDTH] : div_nx[WIDTH-1:0];
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= '0;
      m_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      dz_q     <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      dz_q     <= dz_d;
      result_q <= result_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end
  assign bus.result = result_q;
  assign bus.done   = done_q;
  assign bus.busy   = state_q != IDLE;
  assign bus.error  = error_q;
endmodule

// File: tb/tb_iter_alu_core.sv
// tb_iter_alu_core: directed vectors with hand-computed answers for iter_alu_core (WIDTH=64, MUL_BITS=1)
module tb_iter_alu_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  iter_alu_if #(.WIDTH(64)) bus();
  iter_alu_core #(.WIDTH(64), .MUL_BITS(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int errs = 0;
  int checks = 0;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [2:0] m, input logic [63:0] a, input logic [63:0] b);
    bus.enable = 1'b1;
    bus.mode = m;
    bus.operand_1 = a;
    bus.operand_2 = b;
    @(posedge clk);
    #1;
    bus.enable = 1'b0;
  endtask
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.done && lat < 200);
  endtask
  task automatic run(input string tag, input logic [2:0] m, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] er, input logic ee, input int el);
    int lat;
    issue(m, a, b);
    chk({tag, " busy_after_accept"}, 64'(bus.busy), 64'd1);
    wait_done(lat);
    chk({tag, " done"}, 64'(bus.done), 64'd1);
    chk({tag, " result"}, bus.result, er);
    chk({tag, " error"}, 64'(bus.error), 64'(ee));
    chk({tag, " latency"}, 64'(lat), 64'(el));
    chk({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
  endtask
  initial begin
    int lat;
    int n;
    bus.enable = 1'b0;
    bus.mode = 3'd0;
    bus.operand_1 = '0;
    bus.operand_2 = '0;
    #12;
    chk("reset result", bus.result, 64'd0);
    chk("reset done", 64'(bus.done), 64'd0);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset error", 64'(bus.error), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run("add_wrap", 3'd0, ONES, 64'd1, 64'd0, 1'b0, 1);
    run("sub", 3'd1, 64'd10, 64'd3, 64'd7, 1'b0, 1);
    run("and", 3'd6, 64'hF0F0_0000_FFFF_1234, 64'h0FF0_FFFF_00FF_00FF, 64'h00F0_0000_00FF_0034, 1'b0, 1);
    run("xor", 3'd7, 64'hAAAA_AAAA_5555_5555, ONES, 64'h5555_5555_AAAA_AAAA, 1'b0, 1);
    run("mullo_ones", 3'd2, ONES, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 64);
    run("mulhi_ones", 3'd3, ONES, 64'd2, 64'd1, 1'b0, 64);
    run("mullo_small", 3'd2, 64'd12345, 64'd1000, 64'd12345000, 1'b0, 64);
    run("mulhi_2p32", 3'd3, 64'h1_0000_0000, 64'h1_0000_0000, 64'd1, 1'b0, 64);
    run("mullo_2p32", 3'd2, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 1'b0, 64);
    run("div", 3'd4, 64'd100, 64'd7, 64'd14, 1'b0, 64);
    run("rem", 3'd5, 64'd100, 64'd7, 64'd2, 1'b0, 64);
    run("div_big", 3'd4, ONES, 64'd16, 64'h0FFF_FFFF_FFFF_FFFF, 1'b0, 64);
    run("rem_big", 3'd5, ONES, 64'd16, 64'd15, 1'b0, 64);
    run("div_small_by_big", 3'd4, 64'd3, ONES, 64'd0, 1'b0, 64);
    run("div_zero", 3'd4, 64'd5, 64'd0, ONES, 1'b1, 1);
    @(posedge clk);
    #1;
    chk("error_held", 64'(bus.error), 64'd1);
    chk("result_held", bus.result, ONES);
    chk("done_pulse_one_cycle", 64'(bus.done), 64'd0);
    run("rem_zero", 3'd5, 64'd5, 64'd0, 64'd5, 1'b1, 1);
    run("add_after_dz", 3'd0, 64'd1, 64'd1, 64'd2, 1'b0, 1);
    // a request arriving mid-divide must be dropped, not queued
    issue(3'd4, 64'd1000, 64'd10);
    repeat (5) @(posedge clk);
    #1;
    bus.enable = 1'b1;
    bus.mode = 3'd0;
    bus.operand_1 = 64'd7;
    bus.operand_2 = 64'd3;
    @(posedge clk);
    #1;
    bus.enable = 1'b0;
    wait_done(lat);
    chk("ignore_mid_div latency", 64'(lat + 6), 64'd64);
    chk("ignore_mid_div result", bus.result, 64'd100);
    @(posedge clk);
    #1;
    chk("ignore_mid_div no_extra_op", 64'(bus.busy), 64'd0);
    bus.enable = 1'b1;
    bus.mode = 3'd0;
    bus.operand_1 = 64'd2;
    bus.operand_2 = 64'd3;
    @(posedge clk);
    #1;
    bus.mode = 3'd7;
    bus.operand_1 = 64'd12;
    bus.operand_2 = 64'd10;
    @(posedge clk);
    #1;
    chk("b2b first done", 64'(bus.done), 64'd1);
    chk("b2b first result", bus.result, 64'd5);
    @(posedge clk);
    #1;
    bus.enable = 1'b0;
    chk("b2b rebusy", 64'(bus.busy), 64'd1);
    chk("b2b done_low", 64'(bus.done), 64'd0);
    @(posedge clk);
    #1;
    chk("b2b second done", 64'(bus.done), 64'd1);
    chk("b2b second result", bus.result, 64'd6);
    issue(3'd2, ONES, 64'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid result", bus.result, 64'd0);
    chk("rst_mid busy", 64'(bus.busy), 64'd0);
    chk("rst_mid done", 64'(bus.done), 64'd0);
    chk("rst_mid error", 64'(bus.error), 64'd0);
    #2;
    rst_n = 1'b1;
    n = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      n += int'(bus.done);
    end
    chk("rst_mid no_done", 64'(n), 64'd0);
    run("sub_after_rst", 3'd1, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
